// File: rtl/bicubic_upsample_sched.sv
`default_nettype none
// ============================================================================
// Module   : bicubic_upsample_sched
// Purpose  : Per-channel frame scheduler for the 2x bicubic core. Tags each
//            core beat with output coordinates and buffers beats in a 2-deep skid.
// Optional : BICUBIC_SCHED_PERF_EN adds the perf_stall_cyc/perf_bp_cyc counters.
// Revision : 1.0
// ============================================================================
module bicubic_upsample_sched #(
  parameter int CHANNEL_WIDTH = 8,
  parameter int IMG_W         = 960,
  parameter int IMG_H         = 540,
  parameter int CNT_W         = 11
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       frame_done,
  input  logic                       win_valid,
  output logic                       win_ready,
  output logic                       bf_req_valid,
  input  logic                       bcci_req_ready,
  input  logic                       bcci_rsp_valid,
  output logic                       bf_rsp_ready,
  input  logic [8*CHANNEL_WIDTH-1:0] bcci_rsp_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [8*CHANNEL_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]           out_row,
  output logic [CNT_W-1:0]           out_col,
  output logic                       out_beat,
  output logic                       out_last,
`ifdef BICUBIC_SCHED_PERF_EN
  output logic [31:0]                perf_stall_cyc,
  output logic [31:0]                perf_bp_cyc,
`endif
  output logic                       seq_err
);

  localparam int DW = 8 * CHANNEL_WIDTH;
  localparam int EW = DW + 2 * CNT_W + 2;
  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(IMG_W - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(IMG_H - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    B0    = 2'd1,
    B1    = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] row_q, row_d, col_q, col_d;
  logic [EW-1:0]    ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]       cnt_q, cnt_d;
  logic             seq_err_q, seq_err_d;

  logic             in_beat, rsp_hsk, pop, last_win, start_acc;
  logic [EW-1:0]    new_ent;

  always_comb begin
    in_beat      = (state_q == B0) || (state_q == B1);
    bf_rsp_ready = in_beat && (cnt_q != 2'd2);
    rsp_hsk      = bcci_rsp_valid && bf_rsp_ready;
    out_valid    = (cnt_q != 2'd0);
    pop          = out_valid && out_ready;
    last_win     = (row_q == LAST_ROW) && (col_q == LAST_COL);
    start_acc    = (state_q == IDLE) && start;
    bf_req_valid = win_valid && in_beat;
    win_ready    = (state_q == B1) && rsp_hsk;
    busy         = (state_q != IDLE);
    frame_done   = (state_q == DRAIN) && (cnt_q == 2'd0);
    seq_err      = seq_err_q;
    // Coordinates are stored already doubled: they address output pixel pairs.
    new_ent      = {bcci_rsp_data, row_q << 1, col_q << 1,
                    state_q == B1, (state_q == B1) && last_win};
    {out_data, out_row, out_col, out_beat, out_last} = ent0_q;
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    seq_err_d = seq_err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = B0;
          row_d   = '0;
          col_d   = '0;
        end
      end
      B0: begin
        if (rsp_hsk) begin
          state_d = B1;
          if (!bcci_req_ready) seq_err_d = 1'b1;
        end
      end
      B1: begin
        if (rsp_hsk) begin
          if (bcci_req_ready) seq_err_d = 1'b1;
          state_d = last_win ? DRAIN : B0;
          if (col_q == LAST_COL) begin
            col_d = '0;
            row_d = row_q + 1'b1;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == 2'd0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Entry 0 is always the head; a pop shifts entry 1 forward.
  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({rsp_hsk, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = new_ent;
        else               ent1_d = new_ent;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: ent0_d = new_ent;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      row_q     <= '0;
      col_q     <= '0;
      ent0_q    <= '0;
      ent1_q    <= '0;
      cnt_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      ent0_q    <= ent0_d;
      ent1_q    <= ent1_d;
      cnt_q     <= cnt_d;
      seq_err_q <= seq_err_d;
    end
  end

`ifdef BICUBIC_SCHED_PERF_EN
  logic [31:0] stall_q, stall_d, bp_q, bp_d;

  always_comb begin
    stall_d = stall_q;
    bp_d    = bp_q;
    if (start_acc) begin
      stall_d = '0;
      bp_d    = '0;
    end else begin
      if (in_beat && !win_valid && !(&stall_q)) stall_d = stall_q + 32'd1;
      if (out_valid && !out_ready && !(&bp_q))  bp_d    = bp_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      bp_q    <= '0;
    end else begin
      stall_q <= stall_d;
      bp_q    <= bp_d;
    end
  end

  assign perf_stall_cyc = stall_q;
  assign perf_bp_cyc    = bp_q;
`else
  // Without the perf counters the start-accept term has no consumer.
  logic unused_start_acc;
  assign unused_start_acc = start_acc;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bicubic_upsample_sched.sv
`default_nettype none
// Randomized bench for bicubic_upsample_sched: a behavioural core/frame model
// predicts every handshake, output beat and status flag cycle by cycle.
module tb_bicubic_upsample_sched;

  localparam int CW    = 8;
  localparam int W     = 3;
  localparam int H     = 2;
  localparam int CNT_W = 11;
  localparam int DW    = 8 * CW;
  localparam int TOTAL = 2 * W * H;

  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, win_valid = 1'b0, out_ready = 1'b0;
  logic rv_en = 1'b0, err_mode = 1'b0;
  logic busy, frame_done, win_ready, bf_req_valid, bf_rsp_ready, out_valid;
  logic out_beat, out_last, seq_err;
  logic bcci_req_ready, bcci_rsp_valid;
  logic [DW-1:0] bcci_rsp_data, out_data;
  logic [CNT_W-1:0] out_row, out_col;
`ifdef BICUBIC_SCHED_PERF_EN
  logic [31:0] perf_stall_cyc, perf_bp_cyc;
  int unsigned stall_m = 0, bp_m = 0;
`endif

  int checks = 0, errors = 0;
  int unsigned core_idx = 0, exp_idx = 0, seed = 0, wr_cnt = 0;
  bit busy_m = 0, seq_m = 0, toggle = 0, rand_start = 0;
  int wv_pct = 100, or_pct = 100, rv_pct = 100, or_hold = 0;

  function automatic logic [DW-1:0] mk(input int unsigned s, input int unsigned i);
    return DW'({s ^ (i * 32'h9E37_79B9), ~s + i});
  endfunction

  // Beat i belongs to window i/2, raster-ordered; coordinates are doubled.
  function automatic logic [127:0] exp_head(input int unsigned i);
    int unsigned w = i / 2;
    logic [CNT_W-1:0] r = CNT_W'(2 * (w / W));
    logic [CNT_W-1:0] c = CNT_W'(2 * (w % W));
    bit b = (i % 2) == 1;
    bit l = (i == TOTAL - 1);
    return 128'({mk(seed, i), r, c, b, l});
  endfunction

  // Core model: ready only in its beat-0 phase unless misbehaving on purpose.
  assign bcci_req_ready = err_mode | ~core_idx[0];
  assign bcci_rsp_valid = bf_req_valid & rv_en;
  assign bcci_rsp_data  = mk(seed, core_idx);

  bicubic_upsample_sched #(
    .CHANNEL_WIDTH(CW), .IMG_W(W), .IMG_H(H), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .frame_done(frame_done),
    .win_valid(win_valid), .win_ready(win_ready), .bf_req_valid(bf_req_valid),
    .bcci_req_ready(bcci_req_ready), .bcci_rsp_valid(bcci_rsp_valid),
    .bf_rsp_ready(bf_rsp_ready), .bcci_rsp_data(bcci_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_row(out_row), .out_col(out_col), .out_beat(out_beat), .out_last(out_last),
`ifdef BICUBIC_SCHED_PERF_EN
    .perf_stall_cyc(perf_stall_cyc), .perf_bp_cyc(perf_bp_cyc),
`endif
    .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic cyc();
    bit active, hsk, pp, acc, fd, rr, wv, orr;
    @(negedge clk);
    active = busy_m && (core_idx < TOTAL);
    hsk    = bcci_rsp_valid & bf_rsp_ready;
    pp     = out_valid & out_ready;
    acc    = start && !busy_m;
    fd     = busy_m && (core_idx == TOTAL) && (exp_idx == TOTAL);
    rr     = bcci_req_ready;
    wv     = win_valid;
    orr    = out_ready;
    check("busy", 128'(busy), 128'(busy_m));
    check("bf_req_valid", 128'(bf_req_valid), 128'(wv && active));
    check("bf_rsp_ready", 128'(bf_rsp_ready), 128'(active && (core_idx - exp_idx) < 2));
    check("out_valid", 128'(out_valid), 128'(core_idx != exp_idx));
    check("win_ready", 128'(win_ready), 128'(active && hsk && core_idx[0]));
    check("frame_done", 128'(frame_done), 128'(fd));
    check("seq_err", 128'(seq_err), 128'(seq_m));
    if (core_idx != exp_idx)
      check("head", 128'({out_data, out_row, out_col, out_beat, out_last}), exp_head(exp_idx));
`ifdef BICUBIC_SCHED_PERF_EN
    check("perf_stall", 128'(perf_stall_cyc), 128'(stall_m));
    check("perf_bp", 128'(perf_bp_cyc), 128'(bp_m));
`endif
    if (win_ready) wr_cnt++;
    @(posedge clk);
    #1;
`ifdef BICUBIC_SCHED_PERF_EN
    if (acc) begin
      stall_m = 0;
      bp_m    = 0;
    end else begin
      if (active && !wv) stall_m++;
      if ((core_idx != exp_idx) && !orr) bp_m++;
    end
`endif
    if (hsk) begin
      if (core_idx[0] ? rr : !rr) seq_m = 1;
      core_idx++;
    end
    if (pp) exp_idx++;
    if (fd) busy_m = 0;
    if (acc) begin
      busy_m   = 1;
      core_idx = 0;
      exp_idx  = 0;
    end
    start     = (rand_start && busy_m) ? ($urandom_range(7) == 0) : 1'b0;
    win_valid = toggle ? !win_valid : ($urandom_range(99) < wv_pct);
    if (or_hold > 0) begin
      out_ready = 1'b0;
      or_hold--;
    end else begin
      out_ready = ($urandom_range(99) < or_pct);
    end
    rv_en = ($urandom_range(99) < rv_pct);
  endtask

  task automatic run_frame(input string name);
    int n = 0;
    seed   = $urandom;
    wr_cnt = 0;
    start  = 1'b1;
    cyc();
    while (busy_m && n < 3000) begin
      cyc();
      n++;
    end
    check({name, "_timeout"}, 128'(n < 3000), 128'(1));
    check({name, "_beats"}, 128'(exp_idx), 128'(TOTAL));
    check({name, "_win_ready"}, 128'(wr_cnt), 128'(W * H));
    cyc();
  endtask

  task automatic check_all_zero(input string tag);
    check(tag, 128'({busy, frame_done, win_ready, bf_req_valid, bf_rsp_ready, out_valid,
                     out_data, out_row, out_col, out_beat, out_last, seq_err}), 128'(0));
  endtask

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset_state");
    rst_n = 1'b1;
    cyc();

    run_frame("basic");

    out_ready = 1'b0;
    or_hold   = 25;
    run_frame("skid");

    toggle = 1;
    run_frame("toggle");
    toggle = 0;

    wv_pct = 70; or_pct = 60; rv_pct = 70; rand_start = 1;
    for (int k = 0; k < 6; k++) run_frame("rand");

    err_mode = 1'b1;
    run_frame("seqerr");
    err_mode = 1'b0;
    repeat (3) cyc();
    check("seq_err_sticky", 128'(seq_err), 128'(1));

    // Reset in the middle of a frame, once several beats have left the buffer.
    n = 0;
    seed  = $urandom;
    start = 1'b1;
    cyc();
    while (exp_idx < 5 && n < 1000) begin
      cyc();
      n++;
    end
    check("midrst_reach", 128'(exp_idx >= 5), 128'(1));
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst_zero");
    busy_m = 0; seq_m = 0; core_idx = 0; exp_idx = 0; start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc();
    run_frame("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/bicubic_upsample_sched.md
Name: bicubic_upsample_sched

Overview:
Frame-level scheduler for the 2x bicubic upsample core.
- Gates 4x4 windows from the line-buffer source into the core.
- Holds each window for the core's two response beats and tags each beat with output coordinates.
- Decouples the core from downstream backpressure through a 2-entry skid buffer.
- Sits between the window/line-buffer block and the output packer; one instance per colour channel.

Parameters:
CHANNEL_WIDTH, 8, bits per pixel.
IMG_W, 960, input windows per row (input image width).
IMG_H, 540, input window rows per frame.
CNT_W, 11, width of row/column counters; must satisfy 2^CNT_W > 2*max(IMG_W,IMG_H).

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse; begins a frame when idle
busy  out  1  high from accepted start until frame_done
frame_done  out  1  one-cycle pulse when last beat leaves skid buffer
win_valid  in  1  source window valid
win_ready  out  1  window consumed (pulses on second beat handshake)
bf_req_valid  out  1  request valid to core
bcci_req_ready  in  1  core request ready (high only in core beat 0)
bcci_rsp_valid  in  1  core response valid
bf_rsp_ready  out  1  response ready to core
bcci_rsp_data  in  8*CHANNEL_WIDTH  core outputs data1..data8 packed, data1 in LSBs
out_valid  out  1  downstream valid
out_ready  in  1  downstream ready
out_data  out  8*CHANNEL_WIDTH  beat payload, unmodified
out_row  out  CNT_W  output row pair base = 2*window row
out_col  out  CNT_W  output column base = 2*window col
out_beat  out  1  0 = first core beat, 1 = second
out_last  out  1  final beat of frame
seq_err  out  1  sticky: core beat phase mismatch

Behaviour:
- Reset (async): state IDLE; counters 0; skid empty; all outputs 0.
- States: IDLE, B0, B1, DRAIN.
  - IDLE -> B0 on start. start in any other state is ignored.
  - B0 -> B1 on rsp_hsk (bcci_rsp_valid & bf_rsp_ready).
  - B1 -> B0 on rsp_hsk when not the last window; B1 -> DRAIN on rsp_hsk of the last window.
  - DRAIN -> IDLE when the skid buffer empties; frame_done pulses that same cycle.
- bf_req_valid = win_valid & (B0|B1). The window stays valid and unchanged across both beats because win_ready is 0 in B0.
- win_ready = B1 & rsp_hsk. Exactly one window is consumed per two beats.
- bf_rsp_ready = (B0|B1) & skid count < 2.
- Coordinates:
  - col increments on B1 rsp_hsk and wraps IMG_W-1 -> 0.
  - row increments on col wrap.
  - Last window is row=IMG_H-1, col=IMG_W-1.
- Skid buffer:
  - 2 entries, each holding {data, row*2, col*2, beat, last}.
  - Push on rsp_hsk; pop on out_valid & out_ready. Simultaneous push and pop when count=2 cannot occur because bf_rsp_ready=0.
  - out_valid = count != 0. Head entry drives out_*.
  - Latency: beat accepted in cycle N appears on out_* in cycle N+1 when the buffer was empty.
  - Simultaneous push and pop at count=1 leaves count at 1, with the new entry at the head next cycle.
- seq_err is set and stays set until reset when either:
  - rsp_hsk in B0 with bcci_req_ready=0, or
  - rsp_hsk in B1 with bcci_req_ready=1.
  Scheduling continues regardless.
- busy = state != IDLE.

Optional Feature:
BICUBIC_SCHED_PERF_EN
- Defined: adds outputs perf_stall_cyc (32b) and perf_bp_cyc (32b). Both clear on accepted start and saturate at all-ones.
  - perf_stall_cyc counts cycles in B0/B1 with win_valid=0.
  - perf_bp_cyc counts cycles with out_valid & !out_ready.
- Undefined: these ports and counters are absent; no other change.

Test Plan:
- IMG_W=3, IMG_H=2, win_valid=1, out_ready=1, core model honours two-beat protocol, start pulse -> 12 beats out:
  - out_col 0,0,2,2,4,4; out_row 0 for the first six, then 2.
  - out_beat alternates 0/1; out_last on beat 12 only.
  - win_ready pulses 6 times; frame_done 1 cycle after last pop; busy drops with it.
- out_ready=0 from the first beat -> skid holds 2 entries and bf_rsp_ready=0; core data held. Release out_ready -> beats emerge in order, none lost or duplicated.
- win_valid toggles 0/1 every cycle -> bf_req_valid follows win_valid. Output sequence identical to the first scenario, only stretched in time.
- Core model drives bcci_req_ready=1 during B1 -> seq_err=1 and stays 1 after frame end; frame still completes with 12 beats.
- Assert rst_n=0 mid-frame (after beat 5) -> all outputs 0 immediately. A new start yields a fresh frame beginning at row 0, col 0.
- With BICUBIC_SCHED_PERF_EN: hold win_valid=0 for 7 cycles in B0 and out_ready=0 for 4 cycles with out_valid=1 -> perf_stall_cyc=7, perf_bp_cyc=4.
